wb_host: RTL and testbench

//  Wishbone B4 pipelined initiator. Accepts single read/write commands on a valid/ready

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_host.sv | 138 +++++++++++++
 tb/tb_wb_host.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: host FSM state encoding and the byte-select helper.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } wb_state_e;

    // All-ones byte select for a data bus of dw bits (dw up to 128).
    function automatic logic [15:0] sel_all(input int dw);
        return 16'((32'd1 << (dw / 8)) - 32'd1);
    endfunction

endpackage

// File: rtl/wb_host.sv
// Wishbone B4 pipelined initiator: one outstanding single read/write per command.
// Command port: a transfer happens on a rising edge where cmd_valid & cmd_ready are both 1.
module wb_host
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    input  logic            wb_stall_i,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_dat_i,
    output wb_state_e       dbg_state_o
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT);
    localparam logic [DW/8-1:0] SEL_ALL  = (DW/8)'(sel_all(DW));

    wb_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          ready_q, ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [DW-1:0] rsp_dat_q, rsp_dat_d;
    logic          expired;

    // The cycle whose count is TIMEOUT-1 is the last one in which an ack can still win.
    assign expired = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_dat_d   = rsp_dat_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cmd_valid && ready_q) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    state_d = ST_REQ;
                end
            end
            ST_REQ, ST_WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                // In REQ an ack only counts once the strobe is actually taken.
                if (wb_ack_i && (state_q == ST_WAIT || !wb_stall_i)) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    if (!we_q) begin
                        rsp_dat_d = wb_dat_i;
                    end
                end else if (expired) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (state_q == ST_REQ && !wb_stall_i) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cyc_d   = (state_d != ST_IDLE);
        stb_d   = (state_d == ST_REQ);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_dat     = rsp_dat_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = SEL_ALL;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_host.sv
// Directed bench for wb_host against a small register-file responder with programmable stall/ack timing.
module tb_wb_host;
    import wb_pkg::*;

    localparam int TIMEOUT = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_dat;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stall_i, wb_ack_i;
    logic [31:0] wb_dat_i;
    wb_state_e   dbg_state_o;

    wb_host #(.TIMEOUT(TIMEOUT), .AW(32), .DW(32)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 wb_clk_i = ~wb_clk_i;

    // ---------------- responder model ----------------
    int          cfg_stall = 0;
    int          cfg_ack   = 0;
    logic        cfg_no_ack = 1'b0;
    logic        stray_ack  = 1'b0;
    logic [31:0] mem [16];
    logic        busy = 1'b0, pending = 1'b0;
    int          stall_left = 0, wait_left = 0;

    task automatic do_ack();
        wb_ack_i = 1'b1;
        if (wb_we_o) mem[wb_adr_o[5:2]] = wb_dat_o;
        else         wb_dat_i = mem[wb_adr_o[5:2]];
    endtask

    always @(negedge wb_clk_i) begin
        wb_stall_i = 1'b0;
        wb_ack_i   = stray_ack;
        wb_dat_i   = 32'hDEAD_BEEF;
        if (!wb_rst_i || !wb_cyc_o) begin
            busy    = 1'b0;
            pending = 1'b0;
        end else if (wb_stb_o) begin
            if (!busy) begin
                busy       = 1'b1;
                stall_left = cfg_stall;
            end
            if (stall_left > 0) begin
                wb_stall_i = 1'b1;
                stall_left--;
            end else if (!cfg_no_ack && !pending) begin
                if (cfg_ack == 0) do_ack();
                else begin
                    pending   = 1'b1;
                    wait_left = cfg_ack;
                end
            end
        end else if (pending) begin
            wait_left--;
            if (wait_left == 0) begin
                do_ack();
                pending = 1'b0;
            end
        end
    end

    // ---------------- bus monitor ----------------
    int          stb_cnt = 0, cyc_cnt = 0, rsp_cnt = 0, req_moves = 0;
    logic        prev_stb = 1'b0;
    logic [64:0] prev_req = '0;

    always @(negedge wb_clk_i) begin
        if (wb_stb_o) stb_cnt++;
        if (wb_cyc_o) cyc_cnt++;
        if (rsp_valid) rsp_cnt++;
        if (wb_stb_o && prev_stb && {wb_we_o, wb_adr_o, wb_dat_o} != prev_req) req_moves++;
        prev_stb = wb_stb_o;
        prev_req = {wb_we_o, wb_adr_o, wb_dat_o};
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [32:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input string name);
        int n;
        n = 0;
        @(negedge wb_clk_i);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        while (!cmd_ready && n < 40) begin
            @(negedge wb_clk_i);
            n++;
        end
        check({name, " cmd_accepted"}, 64'(n < 40), 64'd1);
        @(posedge wb_clk_i);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int          n;
        logic        got;
        logic [32:0] exp;
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge wb_clk_i);
            if (rsp_valid) got = 1'b1;
            else n++;
        end
        check({name, " rsp_seen"}, 64'(got), 64'd1);
        if (got && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({name, " rsp_err"}, 64'(rsp_err), 64'(exp[32]));
            check({name, " rsp_dat"}, 64'(rsp_dat), 64'(exp[31:0]));
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          stall;
        int          ack_dly;
        logic        no_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_stb;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int s_stb, s_cyc, s_rsp, bad, k, n;
        logic [31:0] pwm_adr[3];
        logic [31:0] pwm_duty[3];

        vecs[0]  = '{1'b1, 32'h08, 32'h80,   1,  1, 1'b0, 1'b0, 32'h0,    2,  3};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,    0,  0, 1'b0, 1'b0, 32'h1F,   1,  1};
        vecs[2]  = '{1'b0, 32'h08, 32'h0,    2,  3, 1'b0, 1'b0, 32'h80,   3,  6};
        vecs[3]  = '{1'b1, 32'h0C, 32'hCAFE, 0,  2, 1'b0, 1'b0, 32'h80,   1,  3};
        vecs[4]  = '{1'b0, 32'h0C, 32'h0,    3,  2, 1'b0, 1'b0, 32'hCAFE, 4,  6};
        vecs[5]  = '{1'b0, 32'h10, 32'h0,    0,  0, 1'b1, 1'b1, 32'hCAFE, 1, 16};
        vecs[6]  = '{1'b1, 32'h10, 32'h1234, 0,  0, 1'b0, 1'b0, 32'hCAFE, 1,  1};
        vecs[7]  = '{1'b0, 32'h10, 32'h0,    0, 14, 1'b0, 1'b0, 32'h1234, 1, 15};
        vecs[8]  = '{1'b0, 32'h10, 32'h0,    0, 15, 1'b0, 1'b0, 32'h1234, 1, 16};
        vecs[9]  = '{1'b0, 32'h04, 32'h0,    0, 16, 1'b0, 1'b1, 32'h1234, 1, 16};
        vecs[10] = '{1'b0, 32'h04, 32'h0,   20,  0, 1'b0, 1'b1, 32'h1234, 16, 16};
        vecs[11] = '{1'b0, 32'h04, 32'h0,   15,  0, 1'b0, 1'b0, 32'h1F,   16, 16};

        pwm_adr  = '{32'h20, 32'h24, 32'h28};
        pwm_duty = '{32'h40, 32'h80, 32'hC0};

        // ---- reset ----
        wb_rst_i  = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        #12;
        check("reset cyc",       64'(wb_cyc_o),  64'd0);
        check("reset stb",       64'(wb_stb_o),  64'd0);
        check("reset we",        64'(wb_we_o),   64'd0);
        check("reset adr",       64'(wb_adr_o),  64'd0);
        check("reset wdat",      64'(wb_dat_o),  64'd0);
        check("reset sel",       64'(wb_sel_o),  64'hF);
        check("reset cmd_ready", 64'(cmd_ready), 64'd0);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_err",   64'(rsp_err),   64'd0);
        check("reset rsp_dat",   64'(rsp_dat),   64'd0);
        check("reset state",     64'(dbg_state_o), 64'(ST_IDLE));
        idle_cycles(2);
        wb_rst_i = 1'b1;
        idle_cycles(2);
        check("post-reset cmd_ready", 64'(cmd_ready), 64'd1);

        // ---- single write, ack in the strobe cycle: exact cycle timing ----
        cfg_stall = 0; cfg_ack = 0; cfg_no_ack = 1'b0;
        send_cmd(1'b1, 32'h4, 32'h1F, "t1");
        @(negedge wb_clk_i);
        check("t1 stb c1",       64'(wb_stb_o),  64'd1);
        check("t1 cyc c1",       64'(wb_cyc_o),  64'd1);
        check("t1 we c1",        64'(wb_we_o),   64'd1);
        check("t1 adr c1",       64'(wb_adr_o),  64'h4);
        check("t1 wdat c1",      64'(wb_dat_o),  64'h1F);
        check("t1 cmd_ready c1", 64'(cmd_ready), 64'd0);
        check("t1 rsp c1",       64'(rsp_valid), 64'd0);
        @(negedge wb_clk_i);
        check("t1 stb c2",       64'(wb_stb_o),  64'd0);
        check("t1 cyc c2",       64'(wb_cyc_o),  64'd0);
        check("t1 rsp c2",       64'(rsp_valid), 64'd1);
        check("t1 err c2",       64'(rsp_err),   64'd0);
        check("t1 rdat c2",      64'(rsp_dat),   64'd0);
        @(negedge wb_clk_i);
        check("t1 rsp c3",       64'(rsp_valid), 64'd0);
        check("t1 mem",          64'(mem[1]),    64'h1F);

        // ---- stray ack in IDLE ----
        idle_cycles(1);
        s_rsp = rsp_cnt;
        stray_ack = 1'b1;
        idle_cycles(1);
        stray_ack = 1'b0;
        idle_cycles(3);
        check("t6 no rsp",     64'(rsp_cnt - s_rsp), 64'd0);
        check("t6 state",      64'(dbg_state_o),     64'(ST_IDLE));
        check("t6 cyc",        64'(wb_cyc_o),        64'd0);
        check("t6 cmd_ready",  64'(cmd_ready),       64'd1);
        check("t6 rsp_dat",    64'(rsp_dat),         64'd0);

        // ---- table-driven vectors ----
        for (int i = 0; i < 12; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            cfg_stall  = vecs[i].stall;
            cfg_ack    = vecs[i].ack_dly;
            cfg_no_ack = vecs[i].no_ack;
            exp_q.push_back({vecs[i].exp_err, vecs[i].exp_dat});
            s_stb = stb_cnt; s_cyc = cyc_cnt; s_rsp = rsp_cnt;
            send_cmd(vecs[i].we, vecs[i].adr, vecs[i].dat, nm);
            wait_rsp(nm);
            idle_cycles(2);
            check({nm, " stb_cycles"}, 64'(stb_cnt - s_stb), 64'(vecs[i].exp_stb));
            check({nm, " cyc_cycles"}, 64'(cyc_cnt - s_cyc), 64'(vecs[i].exp_cyc));
            check({nm, " rsp_count"},  64'(rsp_cnt - s_rsp), 64'd1);
            check({nm, " cmd_ready"},  64'(cmd_ready),       64'd1);
        end
        check("request stable while stalled", 64'(req_moves), 64'd0);
        check("mem 0xC", 64'(mem[3]), 64'hCAFE);

        // ---- back-to-back writes with cmd_valid held ----
        cfg_stall = 0; cfg_ack = 0; cfg_no_ack = 1'b0;
        s_stb = stb_cnt; s_rsp = rsp_cnt;
        bad = 0; k = 0; n = 0;
        @(negedge wb_clk_i);
        cmd_valid = 1'b1; cmd_we = 1'b1;
        cmd_adr = pwm_adr[0]; cmd_dat = pwm_duty[0];
        while (k < 3 && n < 60) begin
            if (wb_cyc_o && cmd_ready) bad++;
            if (cmd_ready) begin
                @(posedge wb_clk_i);
                #1;
                k++;
                if (k < 3) begin
                    cmd_adr = pwm_adr[k];
                    cmd_dat = pwm_duty[k];
                end else begin
                    cmd_valid = 1'b0;
                end
            end else begin
                @(posedge wb_clk_i);
                #1;
            end
            n++;
            @(negedge wb_clk_i);
            if (wb_cyc_o && cmd_ready) bad++;
        end
        idle_cycles(4);
        check("t4 handshakes", 64'(k),                 64'd3);
        check("t4 strobes",    64'(stb_cnt - s_stb),   64'd3);
        check("t4 responses",  64'(rsp_cnt - s_rsp),   64'd3);
        check("t4 ready low in cycle", 64'(bad),       64'd0);
        check("t4 duty ch0",   64'(mem[8]),            64'h40);
        check("t4 duty ch1",   64'(mem[9]),            64'h80);
        check("t4 duty ch2",   64'(mem[10]),           64'hC0);

        // ---- reset asserted during WAIT ----
        cfg_stall = 0; cfg_ack = 0; cfg_no_ack = 1'b1;
        s_rsp = rsp_cnt;
        send_cmd(1'b0, 32'h8, 32'h0, "t5");
        repeat (3) @(negedge wb_clk_i);
        check("t5 in WAIT", 64'(dbg_state_o), 64'(ST_WAIT));
        #2 wb_rst_i = 1'b0;
        #1;
        check("t5 cyc async",       64'(wb_cyc_o),  64'd0);
        check("t5 stb async",       64'(wb_stb_o),  64'd0);
        check("t5 rsp_valid async", 64'(rsp_valid), 64'd0);
        check("t5 cmd_ready async", 64'(cmd_ready), 64'd0);
        idle_cycles(2);
        wb_rst_i = 1'b1;
        idle_cycles(20);
        check("t5 no response",   64'(rsp_cnt - s_rsp), 64'd0);
        check("t5 state IDLE",    64'(dbg_state_o),     64'(ST_IDLE));
        check("t5 cmd_ready",     64'(cmd_ready),       64'd1);
        check("t5 cyc idle",      64'(wb_cyc_o),        64'd0);

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
